// File: rtl/key_debounce_pulse_pkg.sv
// Shared types and constants for the key debounce / press-pulse stage.
// The state encoding is fixed so that debug tools can decode state_q directly.
package key_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } kdp_state_e;

  // Short window for simulation; 10 ms at 50 MHz for silicon builds.
  localparam int unsigned DEBOUNCE_CYCLES_SIM     = 4;
  localparam int unsigned DEBOUNCE_CYCLES_SILICON = 500000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Reused by every async input in the system; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // its pre-edge input value, exactly like the hardware chain it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounces a raw key and emits one-cycle press/release pulses plus a clean level.
// press_pulse feeds the X input of the downstream saturating press counter.
module key_debounce_pulse
  import key_debounce_pulse_pkg::*;
#(
  parameter  int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic key_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_sync;
  kdp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             level_q, level_d;

  sync_2ff u_key_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (key_in),
    .q       (key_sync)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_sync) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!key_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!key_sync) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (key_sync) begin
          // A bounce back high returns to PRESSED silently; no second press.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Level follows the next state so it rises together with press_pulse.
    level_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      level_q   <= level_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign key_level     = level_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse with DEBOUNCE_CYCLES = 4.
// Edge k = first clock edge at which the synchronizer sees the new key level.
module tb_key_debounce_pulse;
  import key_debounce_pulse_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic key_in  = 1'b0;
  logic press_pulse;
  logic release_pulse;
  logic key_level;

  int checks = 0;
  int errors = 0;

  int press_seen;
  int release_seen;
  int both_seen;
  int sat_cnt;
  logic [7:0] exp_sat [4];

  key_debounce_pulse #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .key_in        (key_in),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .key_level     (key_level)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
    press_seen   += int'(press_pulse);
    release_seen += int'(release_pulse);
    both_seen    += int'(press_pulse & release_pulse);
  endtask

  task automatic clear_seen();
    press_seen   = 0;
    release_seen = 0;
    both_seen    = 0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic p, input logic r, input logic l);
    check({tag, ".press"},   8'(press_pulse),   8'(p));
    check({tag, ".release"}, 8'(release_pulse), 8'(r));
    check({tag, ".level"},   8'(key_level),     8'(l));
  endtask

  initial begin
    exp_sat[0] = 8'd1; exp_sat[1] = 8'd2; exp_sat[2] = 8'd3; exp_sat[3] = 8'd3;
    clear_seen();

    // Reset then idle
    repeat (2) tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    check("reset.state", 8'(dut.state_q), 8'(IDLE));
    reset_n = 1'b1;
    clear_seen();
    repeat (20) tick();
    check("idle.press_cnt", 8'(press_seen), 8'd0);
    check("idle.release_cnt", 8'(release_seen), 8'd0);
    check_outs("idle", 1'b0, 1'b0, 1'b0);
    check("idle.state", 8'(dut.state_q), 8'(IDLE));

    // Clean press: pulse after edge k+6 (7th tick), one cycle wide
    key_in = 1'b1;
    clear_seen();
    repeat (6) tick();
    check("press.early", 8'(press_seen), 8'd0);
    check("press.early_level", 8'(key_level), 8'd0);
    tick();
    check_outs("press.k6", 1'b1, 1'b0, 1'b1);
    check("press.state", 8'(dut.state_q), 8'(PRESSED));
    tick();
    check_outs("press.k7", 1'b0, 1'b0, 1'b1);
    clear_seen();
    repeat (50) tick();
    check("hold.press_cnt", 8'(press_seen), 8'd0);
    check("hold.release_cnt", 8'(release_seen), 8'd0);
    check("hold.level", 8'(key_level), 8'd1);

    // Release with a one-sample bounce high seen when cnt == 2: pulse at j+10
    key_in = 1'b0;
    clear_seen();
    repeat (3) tick();
    key_in = 1'b1;
    tick();
    key_in = 1'b0;
    repeat (6) tick();
    check("rel.early", 8'(release_seen), 8'd0);
    check("rel.early_press", 8'(press_seen), 8'd0);
    check("rel.early_level", 8'(key_level), 8'd1);
    tick();
    check_outs("rel.j10", 1'b0, 1'b1, 1'b0);
    check("rel.state", 8'(dut.state_q), 8'(IDLE));
    tick();
    check_outs("rel.j11", 1'b0, 1'b0, 1'b0);

    // Bounce rejection: high 3, low 1, high 3, low
    clear_seen();
    key_in = 1'b1;
    repeat (3) tick();
    key_in = 1'b0;
    tick();
    key_in = 1'b1;
    repeat (3) tick();
    key_in = 1'b0;
    repeat (10) tick();
    check("bounce.press_cnt", 8'(press_seen), 8'd0);
    check("bounce.level", 8'(key_level), 8'd0);
    check("bounce.state", 8'(dut.state_q), 8'(IDLE));
    clear_seen();
    key_in = 1'b1;
    repeat (10) tick();
    check("bounce10.press_cnt", 8'(press_seen), 8'd1);
    check("bounce10.level", 8'(key_level), 8'd1);
    clear_seen();
    key_in = 1'b0;
    repeat (12) tick();
    check("bounce10.release_cnt", 8'(release_seen), 8'd1);
    check("bounce10.press_after", 8'(press_seen), 8'd0);
    check("bounce10.level_off", 8'(key_level), 8'd0);

    // Low sample on the final count cycle (cnt == 3) still rejects
    clear_seen();
    key_in = 1'b1;
    repeat (4) tick();
    key_in = 1'b0;
    repeat (2) tick();
    check("final.state", 8'(dut.state_q), 8'(PRESS_CHK));
    check("final.cnt", 8'(dut.cnt_q), 8'd3);
    tick();
    check("final.state_after", 8'(dut.state_q), 8'(IDLE));
    repeat (5) tick();
    check("final.press_cnt", 8'(press_seen), 8'd0);
    check("final.level", 8'(key_level), 8'd0);

    // Reset at edge k+4 while still qualifying; requalify after reset
    clear_seen();
    key_in = 1'b1;
    repeat (5) tick();
    check("rstmid.press_cnt", 8'(press_seen), 8'd0);
    check("rstmid.state_pre", 8'(dut.state_q), 8'(PRESS_CHK));
    reset_n = 1'b0;
    #1;
    check("rstmid.state", 8'(dut.state_q), 8'(IDLE));
    check("rstmid.cnt", 8'(dut.cnt_q), 8'd0);
    #2;
    reset_n = 1'b1;
    clear_seen();
    repeat (6) tick();
    check("rstmid.early", 8'(press_seen), 8'd0);
    tick();
    check_outs("rstmid.k6", 1'b1, 1'b0, 1'b1);

    // Asynchronous clear while PRESSED, mid-cycle; key still held -> requalify
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_outs("async", 1'b0, 1'b0, 1'b0);
    check("async.state", 8'(dut.state_q), 8'(IDLE));
    #1;
    reset_n = 1'b1;
    clear_seen();
    repeat (6) tick();
    check("async.early", 8'(press_seen), 8'd0);
    tick();
    check_outs("async.k6", 1'b1, 1'b0, 1'b1);
    key_in = 1'b0;
    repeat (12) tick();
    check_outs("async.idle", 1'b0, 1'b0, 1'b0);

    // Four clean presses driving a 2-bit saturating press counter model
    sat_cnt = 0;
    clear_seen();
    for (int p = 0; p < 4; p++) begin
      key_in = 1'b1;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (press_pulse && sat_cnt < 3) sat_cnt++;
      end
      key_in = 1'b0;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (press_pulse && sat_cnt < 3) sat_cnt++;
      end
      check($sformatf("ctr.press%0d", p), 8'(sat_cnt), exp_sat[p]);
    end
    check("ctr.press_total", 8'(press_seen), 8'd4);
    check("ctr.release_total", 8'(release_seen), 8'd4);
    check("ctr.never_both", 8'(both_seen), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
